// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
// Shared types, constants and index helpers for the binary conv/pool layer.
//   state_t  : FSM states of bnn_conv_pool (IDLE, RUN, DONE)
//   KSIZE    : convolution kernel edge (3x3)
//   PSIZE    : max-pool window edge (2x2)
//   pix_idx  : bit position of pixel (ci, r, c) in the flattened pixel bus
//   wt_idx   : bit position of weight (co, ci, kr, kc) in the flattened weight bus
//   out_idx  : bit position of pooled output (co, pr, pc) in layer_out
//   idx_w    : counter/index width for a range of n values, never below 1
// -----------------------------------------------------------------------------
package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int KSIZE = 3;
    localparam int PSIZE = 2;

    function automatic int pix_idx(input int ci, input int r, input int c,
                                   input int h, input int w);
        return (ci * h + r) * w + c;
    endfunction

    function automatic int wt_idx(input int co, input int ci, input int kr,
                                  input int kc, input int in_ch);
        return (co * in_ch + ci) * (KSIZE * KSIZE) + kr * KSIZE + kc;
    endfunction

    function automatic int out_idx(input int co, input int pr, input int pc,
                                   input int ph, input int pw);
        return (co * ph + pr) * pw + pc;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// -----------------------------------------------------------------------------
// bnn_xnor_popcount
// Purely combinational XNOR-popcount: counts positions where act and wt agree.
// Ports:
//   act [N-1:0]     binary activations (window taps of all input channels)
//   wt  [N-1:0]     binary weights, same ordering as act
//   pop [POP_W-1:0] number of agreeing positions (0..N)
// -----------------------------------------------------------------------------
module bnn_xnor_popcount
    import bnn_pkg::*;
#(
    parameter int N     = KSIZE * KSIZE,
    parameter int POP_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     act,
    input  logic [N-1:0]     wt,
    output logic [POP_W-1:0] pop
);

    logic [N-1:0] match;

    assign match = ~(act ^ wt);

    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + POP_W'(match[i]);
        end
    end

endmodule

// File: rtl/bnn_conv_pool.sv
// -----------------------------------------------------------------------------
// bnn_conv_pool
// Binary conv layer: 3x3 XNOR-popcount convolution over IN_CH binary planes,
// per-output-channel threshold (pop > thr), then 2x2 max-pool (OR).
// One conv position is evaluated per cycle; the four positions of a pool
// window are visited back to back, so each pooled bit takes 4 cycles.
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset
//   start       begin a pass (honoured only in IDLE or DONE)
//   pixels      bit (ci*IMG_H+r)*IMG_W+c, held stable while busy
//   weights     bit (co*IN_CH+ci)*9+kr*3+kc, held stable while busy
//   thresholds  field co at [co*THR_W +: THR_W], held stable while busy
//   layer_out   bit (co*(IMG_H/2)+pr)*(IMG_W/2)+pc
//   busy        high while a pass is running
//   done        high from pass completion until the next start
// Optional (macro BNN_OUT_STREAM_EN):
//   out_valid   one-cycle pulse per layer_out write
//   out_bit     value written
//   out_ch/out_row/out_col  coordinates of that write
// -----------------------------------------------------------------------------
module bnn_conv_pool
    import bnn_pkg::*;
#(
    parameter int IMG_H  = 28,
    parameter int IMG_W  = 28,
    parameter int IN_CH  = 1,
    parameter int OUT_CH = 8,
    parameter int THR_W  = $clog2(9 * IN_CH + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [IN_CH*IMG_H*IMG_W-1:0]          pixels,
    input  logic [OUT_CH*IN_CH*9-1:0]             weights,
    input  logic [OUT_CH*THR_W-1:0]               thresholds,
    output logic [OUT_CH*(IMG_H/2)*(IMG_W/2)-1:0] layer_out,
    output logic                                  busy,
    output logic                                  done
`ifdef BNN_OUT_STREAM_EN
    ,
    output logic                                  out_valid,
    output logic                                  out_bit,
    output logic [idx_w(OUT_CH)-1:0]              out_ch,
    output logic [idx_w(IMG_H/2)-1:0]             out_row,
    output logic [idx_w(IMG_W/2)-1:0]             out_col
`endif
);

    localparam int N      = KSIZE * KSIZE * IN_CH;
    localparam int PH     = IMG_H / PSIZE;
    localparam int PW     = IMG_W / PSIZE;
    localparam int CO_W   = idx_w(OUT_CH);
    localparam int PR_W   = idx_w(PH);
    localparam int PC_W   = idx_w(PW);
    localparam int PIX_AW = idx_w(IN_CH * IMG_H * IMG_W);
    localparam int OUT_AW = idx_w(OUT_CH * PH * PW);

    state_t          state;
    logic [CO_W-1:0] co;
    logic [PR_W-1:0] pr;
    logic [PC_W-1:0] pc;
    logic [1:0]      pool_cnt;
    logic            pool_acc;

    int               row;
    int               col;
    logic [N-1:0]     act;
    logic [N-1:0]     wt;
    logic [THR_W-1:0] pop;
    logic [THR_W-1:0] thr;
    logic             conv_bit;
    logic             last_pos;
    logic             pooled;

    // Conv position inside the current pool window: bit 1 of pool_cnt picks
    // the row, bit 0 the column.
    always_comb begin
        row = PSIZE * int'(pr) + int'(pool_cnt[1]);
        col = PSIZE * int'(pc) + int'(pool_cnt[0]);
    end

    // Gather the 3x3 window of every input channel; taps falling outside the
    // image read as 0 (not as "don't care"), which still XNORs against the
    // weight and can contribute to the popcount.
    always_comb begin
        act = '0;
        for (int ci = 0; ci < IN_CH; ci++) begin
            for (int kr = 0; kr < KSIZE; kr++) begin
                for (int kc = 0; kc < KSIZE; kc++) begin
                    if ((row + kr - 1 >= 0) && (row + kr - 1 < IMG_H) &&
                        (col + kc - 1 >= 0) && (col + kc - 1 < IMG_W)) begin
                        act[(ci * KSIZE + kr) * KSIZE + kc] =
                            pixels[PIX_AW'(pix_idx(ci, row + kr - 1, col + kc - 1,
                                                   IMG_H, IMG_W))];
                    end
                end
            end
        end
    end

    // Weight block and threshold of the current output channel. The weight
    // bits of one filter are contiguous, so a single slice per channel works.
    always_comb begin
        wt  = '0;
        thr = '0;
        for (int k = 0; k < OUT_CH; k++) begin
            if (co == CO_W'(k)) begin
                wt  = weights[wt_idx(k, 0, 0, 0, IN_CH) +: N];
                thr = thresholds[k * THR_W +: THR_W];
            end
        end
    end

    bnn_xnor_popcount #(
        .N     (N),
        .POP_W (THR_W)
    ) u_popcount (
        .act (act),
        .wt  (wt),
        .pop (pop)
    );

    assign conv_bit = (pop > thr);
    assign pooled   = pool_acc | conv_bit;
    assign last_pos = (pool_cnt == 2'd3) && (pc == PC_W'(PW - 1)) &&
                      (pr == PR_W'(PH - 1)) && (co == CO_W'(OUT_CH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            co        <= '0;
            pr        <= '0;
            pc        <= '0;
            pool_cnt  <= '0;
            pool_acc  <= 1'b0;
            layer_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef BNN_OUT_STREAM_EN
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_ch    <= '0;
            out_row   <= '0;
            out_col   <= '0;
`endif
        end else begin
`ifdef BNN_OUT_STREAM_EN
            out_valid <= 1'b0;
`endif
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        co       <= '0;
                        pr       <= '0;
                        pc       <= '0;
                        pool_cnt <= '0;
                        pool_acc <= 1'b0;
                    end
                end

                RUN: begin
                    pool_cnt <= pool_cnt + 2'd1;
                    if (pool_cnt == 2'd3) begin
                        // Last tap of the pool window: commit and restart the OR.
                        layer_out[OUT_AW'(out_idx(int'(co), int'(pr), int'(pc),
                                                  PH, PW))] <= pooled;
                        pool_acc <= 1'b0;
`ifdef BNN_OUT_STREAM_EN
                        out_valid <= 1'b1;
                        out_bit   <= pooled;
                        out_ch    <= co;
                        out_row   <= pr;
                        out_col   <= pc;
`endif
                        if (pc == PC_W'(PW - 1)) begin
                            pc <= '0;
                            if (pr == PR_W'(PH - 1)) begin
                                pr <= '0;
                                if (co == CO_W'(OUT_CH - 1)) begin
                                    co <= '0;
                                end else begin
                                    co <= co + CO_W'(1);
                                end
                            end else begin
                                pr <= pr + PR_W'(1);
                            end
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                    end else begin
                        pool_acc <= pooled;
                    end

                    if (last_pos) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_conv_pool.sv
// -----------------------------------------------------------------------------
// tb_bnn_conv_pool
// Two instances: the default 28x28x1 -> 14x14x8 layer driven from a table of
// hand-derived vectors and multi-cycle sequences, and an 8x8x2 -> 4x4x4 layer
// driven with random vectors against a reference model of the layer maths.
// -----------------------------------------------------------------------------
module tb_bnn_conv_pool;

    // Default instance geometry
    localparam int D_PIX = 784;
    localparam int D_WT  = 72;
    localparam int D_TH  = 32;
    localparam int D_OUT = 1568;
    localparam int D_LAT = 6272;

    // Small instance geometry: 8x8, IN_CH=2, OUT_CH=4, THR_W=5
    localparam int S_H   = 8;
    localparam int S_W   = 8;
    localparam int S_IC  = 2;
    localparam int S_OC  = 4;
    localparam int S_TW  = 5;
    localparam int S_LAT = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               d_rst_n, d_start, d_busy, d_done;
    logic [D_PIX-1:0]   d_px;
    logic [D_WT-1:0]    d_w;
    logic [D_TH-1:0]    d_th;
    logic [D_OUT-1:0]   d_out;

    logic               s_rst_n, s_start, s_busy, s_done;
    logic [127:0]       s_px;
    logic [71:0]        s_w;
    logic [19:0]        s_th;
    logic [63:0]        s_out;

`ifdef BNN_OUT_STREAM_EN
    logic       d_ov, d_ob;
    logic [2:0] d_och;
    logic [3:0] d_orow, d_ocol;
    logic       s_ov, s_ob;
    logic [1:0] s_och, s_orow, s_ocol;
`endif

    bnn_conv_pool u_dut_d (
        .clk        (clk),
        .rst_n      (d_rst_n),
        .start      (d_start),
        .pixels     (d_px),
        .weights    (d_w),
        .thresholds (d_th),
        .layer_out  (d_out),
        .busy       (d_busy),
        .done       (d_done)
`ifdef BNN_OUT_STREAM_EN
        ,
        .out_valid  (d_ov),
        .out_bit    (d_ob),
        .out_ch     (d_och),
        .out_row    (d_orow),
        .out_col    (d_ocol)
`endif
    );

    bnn_conv_pool #(
        .IMG_H  (S_H),
        .IMG_W  (S_W),
        .IN_CH  (S_IC),
        .OUT_CH (S_OC)
    ) u_dut_s (
        .clk        (clk),
        .rst_n      (s_rst_n),
        .start      (s_start),
        .pixels     (s_px),
        .weights    (s_w),
        .thresholds (s_th),
        .layer_out  (s_out),
        .busy       (s_busy),
        .done       (s_done)
`ifdef BNN_OUT_STREAM_EN
        ,
        .out_valid  (s_ov),
        .out_bit    (s_ob),
        .out_ch     (s_och),
        .out_row    (s_orow),
        .out_col    (s_ocol)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Number of differing bits (at least 1 if any bit is X/Z or differs).
    function automatic int vdiff_d(input logic [D_OUT-1:0] a, input logic [D_OUT-1:0] b);
        if (a === b) return 0;
        return ($countones(a ^ b) > 0) ? $countones(a ^ b) : 1;
    endfunction

    function automatic int vdiff_s(input logic [63:0] a, input logic [63:0] b);
        if (a === b) return 0;
        return ($countones(a ^ b) > 0) ? $countones(a ^ b) : 1;
    endfunction

    // Reference model of the small layer: for every pooled cell, OR the
    // thresholded popcounts of its four conv positions; outside pixels are 0.
    function automatic logic [63:0] model_s(input logic [127:0] px,
                                            input logic [71:0]  w,
                                            input logic [19:0]  th);
        logic [63:0] res;
        res = '0;
        for (int co = 0; co < S_OC; co++) begin
            for (int pr = 0; pr < S_H / 2; pr++) begin
                for (int pc = 0; pc < S_W / 2; pc++) begin
                    logic acc;
                    acc = 1'b0;
                    for (int dr = 0; dr < 2; dr++) begin
                        for (int dc = 0; dc < 2; dc++) begin
                            int pop;
                            pop = 0;
                            for (int ci = 0; ci < S_IC; ci++) begin
                                for (int kr = 0; kr < 3; kr++) begin
                                    for (int kc = 0; kc < 3; kc++) begin
                                        int rr, cc;
                                        logic p, wb;
                                        rr = 2 * pr + dr + kr - 1;
                                        cc = 2 * pc + dc + kc - 1;
                                        p  = 1'b0;
                                        if (rr >= 0 && rr < S_H && cc >= 0 && cc < S_W)
                                            p = px[7'((ci * S_H + rr) * S_W + cc)];
                                        wb = w[7'((co * S_IC + ci) * 9 + kr * 3 + kc)];
                                        if (p == wb) pop++;
                                    end
                                end
                            end
                            if (pop > int'(th[5'(co * S_TW) +: S_TW])) acc = 1'b1;
                        end
                    end
                    res[6'((co * (S_H / 2) + pr) * (S_W / 2) + pc)] = acc;
                end
            end
        end
        return res;
    endfunction

    typedef struct {
        string            name;
        logic [D_PIX-1:0] px;
        logic [D_WT-1:0]  w;
        logic [D_TH-1:0]  th;
        logic [D_OUT-1:0] exp;
    } vec_t;

    vec_t tbl[5];

    task automatic d_pulse_start();
        d_start = 1'b1;
        @(posedge clk);
        #1;
        d_start = 1'b0;
    endtask

    // Called just after the start edge. lat = edges from the start edge until
    // done is seen (-1 on timeout); bcnt = sampled busy-high cycles.
    task automatic d_wait_done(input int pulse_at, output int lat, output int bcnt);
        lat  = -1;
        bcnt = (d_busy === 1'b1) ? 1 : 0;
        for (int i = 1; i <= D_LAT + 500; i++) begin
            if (i == pulse_at) d_start = 1'b1;
            @(posedge clk);
            #1;
            d_start = 1'b0;
            if (d_done === 1'b1) begin
                lat = i;
                break;
            end
            if (d_busy === 1'b1) bcnt++;
        end
    endtask

    task automatic d_load(input int k);
        d_px = tbl[k].px;
        d_w  = tbl[k].w;
        d_th = tbl[k].th;
    endtask

    task automatic run_small(input string name);
        logic [63:0] exp;
        int lat, pulses;
        exp    = model_s(s_px, s_w, s_th);
        lat    = -1;
        pulses = 0;
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        for (int i = 1; i <= S_LAT + 100; i++) begin
            @(posedge clk);
            #1;
`ifdef BNN_OUT_STREAM_EN
            if (s_ov === 1'b1) begin
                if (pulses < 64) begin
                    check({name, " stream_bit"}, int'(s_ob),   int'(exp[6'(pulses)]));
                    check({name, " stream_ch"},  int'(s_och),  pulses / 16);
                    check({name, " stream_row"}, int'(s_orow), (pulses / 4) % 4);
                    check({name, " stream_col"}, int'(s_ocol), pulses % 4);
                end
                pulses++;
            end
`endif
            if (s_done === 1'b1) begin
                lat = i;
                break;
            end
        end
        check({name, " latency"}, lat, S_LAT);
        check({name, " layer_out diff bits"}, vdiff_s(s_out, exp), 0);
`ifdef BNN_OUT_STREAM_EN
        check({name, " stream pulses"}, pulses, 64);
`endif
    endtask

    initial begin
        int lat, bcnt;

        // ---- vector table: default geometry ----
        tbl[0].name = "all_ones";
        tbl[0].px = '0; tbl[0].w = '0; tbl[0].th = {8{4'd8}};
        tbl[0].exp = '1;

        tbl[1].name = "all_zeros";
        tbl[1].px = '0; tbl[1].w = '1; tbl[1].th = '0;
        tbl[1].exp = '0;

        tbl[2].name = "strict_gt";
        tbl[2].px = '0; tbl[2].w = '0; tbl[2].th = {{7{4'd9}}, 4'd8};
        tbl[2].exp = '0; tbl[2].exp[195:0] = '1;

        tbl[3].name = "single_pixel";
        tbl[3].px = '0; tbl[3].px[377] = 1'b1;
        tbl[3].w = {{7{9'h1FF}}, 9'b000010000};
        tbl[3].th = {8{4'd8}};
        tbl[3].exp = '0; tbl[3].exp[90] = 1'b1;

        tbl[4].name = "corner_padding";
        tbl[4].px = '0; tbl[4].px[0] = 1'b1;
        tbl[4].w = {{7{9'h1FF}}, 9'b000010000};
        tbl[4].th = {8{4'd8}};
        tbl[4].exp = '0; tbl[4].exp[0] = 1'b1;

        // ---- reset ----
        d_rst_n = 1'b0; d_start = 1'b0; d_px = '0; d_w = '0; d_th = '0;
        s_rst_n = 1'b0; s_start = 1'b0; s_px = '0; s_w = '0; s_th = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", int'(d_busy), 0);
        check("reset done", int'(d_done), 0);
        check("reset layer_out diff bits", vdiff_d(d_out, '0), 0);
        check("reset small done", int'(s_done), 0);
        check("reset small layer_out diff bits", vdiff_s(s_out, '0), 0);
        d_rst_n = 1'b1;
        s_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- table-driven passes ----
        for (int k = 0; k < 5; k++) begin
            d_load(k);
            d_pulse_start();
            check({tbl[k].name, " busy after start"}, int'(d_busy), 1);
            d_wait_done(-1, lat, bcnt);
            check({tbl[k].name, " latency"}, lat, D_LAT);
            check({tbl[k].name, " busy cycles"}, bcnt, D_LAT);
            check({tbl[k].name, " layer_out diff bits"}, vdiff_d(d_out, tbl[k].exp), 0);
        end

        // ---- reset in the middle of a pass ----
        d_load(0);
        d_pulse_start();
        repeat (1000) @(posedge clk);
        #1;
        check("midrun busy before reset", int'(d_busy), 1);
        d_rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrun reset busy", int'(d_busy), 0);
        check("midrun reset done", int'(d_done), 0);
        check("midrun reset layer_out diff bits", vdiff_d(d_out, '0), 0);
        d_rst_n = 1'b1;
        @(posedge clk);
        #1;
        d_pulse_start();
        d_wait_done(-1, lat, bcnt);
        check("after reset latency", lat, D_LAT);
        check("after reset layer_out diff bits", vdiff_d(d_out, tbl[0].exp), 0);

        // ---- start pulsed mid-run is ignored ----
        d_load(2);
        d_pulse_start();
        d_wait_done(500, lat, bcnt);
        check("ignored start latency", lat, D_LAT);
        check("ignored start layer_out diff bits", vdiff_d(d_out, tbl[2].exp), 0);

        // ---- start while in DONE ----
        check("done held", int'(d_done), 1);
        repeat (3) @(posedge clk);
        #1;
        check("done still held", int'(d_done), 1);
        d_load(3);
        d_pulse_start();
        check("restart done dropped", int'(d_done), 0);
        check("restart busy", int'(d_busy), 1);
        d_wait_done(-1, lat, bcnt);
        check("restart latency", lat, D_LAT);
        check("restart layer_out diff bits", vdiff_d(d_out, tbl[3].exp), 0);

        // ---- small geometry, random vectors vs. model ----
        for (int t = 0; t < 5; t++) begin
            s_px = {$urandom, $urandom, $urandom, $urandom};
            s_w  = {8'($urandom), $urandom, $urandom};
            for (int k = 0; k < S_OC; k++)
                s_th[5'(k * S_TW) +: S_TW] = 5'($urandom_range(14, 4));
            run_small($sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
